// File: rtl/dshot_rx_bank.sv
// dshot_rx_bank: NUM_CH independent DShot receivers with CRC check,
// command/throttle split, 8-bit speed scaling and no-signal failsafe.
module dshot_rx_bank #(
   parameter int NUM_CH      = 4,
   parameter int CLK_HZ      = 16000000,
   parameter int DSHOT_RATE  = 150000,
   parameter int TIMEOUT_CYC = 1600000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CH-1:0]    dshot_in,
   output logic [NUM_CH*11-1:0] throttle,
   output logic [NUM_CH-1:0]    telem,
   output logic [NUM_CH*8-1:0]  speed,
   output logic [NUM_CH-1:0]    frame_valid,
   output logic [NUM_CH-1:0]    cmd_valid,
   output logic [NUM_CH-1:0]    frame_err,
   output logic [NUM_CH-1:0]    failsafe
);
   localparam int BIT_CYC = CLK_HZ / DSHOT_RATE;
   localparam int THR_CYC = BIT_CYC / 2;
   localparam int MIN_CYC = BIT_CYC / 8;
   localparam int CW = $clog2(2 * BIT_CYC + 2);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] BIT_LIM = CW'(BIT_CYC);
   localparam logic [CW-1:0] LOW_LIM = CW'(2 * BIT_CYC);
   localparam logic [CW-1:0] THR_LIM = CW'(THR_CYC);
   localparam logic [CW-1:0] MIN_LIM = CW'(MIN_CYC);
   localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, CHECK} state_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic s1_q, s2_q, prev_q;
      state_t state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [15:0] sh_q, sh_d;
      logic [4:0] bits_q, bits_d;
      logic [TW-1:0] to_q, to_d;
      logic [10:0] thr_q, thr_d;
      logic [7:0] spd_q, spd_d;
      logic tel_q, tel_d;
      logic fv_q, fv_d;
      logic cmd_q, cmd_d;
      logic err_q, err_d;
      logic fs_q, fs_d;
      logic rise, fall;
      logic [11:0] v;
      logic [10:0] v_thr;
      logic [3:0] crc;

      assign rise  = s2_q & ~prev_q;
      assign fall  = ~s2_q & prev_q;
      assign v     = sh_q[15:4];
      assign v_thr = v[11:1];
      assign crc   = v[3:0] ^ v[7:4] ^ v[11:8];

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         sh_d    = sh_q;
         bits_d  = bits_q;
         thr_d   = thr_q;
         tel_d   = tel_q;
         spd_d   = spd_q;
         fs_d    = fs_q;
         fv_d    = 1'b0;
         cmd_d   = 1'b0;
         err_d   = 1'b0;
         to_d    = (to_q == TO_LIM) ? to_q : to_q + TW'(1);
         if (to_d == TO_LIM) begin
            fs_d  = 1'b1;
            thr_d = '0;
            spd_d = '0;
         end
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = HIGH;
                  cnt_d   = CW'(1);
                  sh_d    = '0;
                  bits_d  = '0;
               end
            end
            HIGH: begin
               if (fall) begin
                  if (cnt_q < MIN_LIM) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     sh_d    = {sh_q[14:0], cnt_q >= THR_LIM};
                     bits_d  = bits_q + 5'd1;
                     cnt_d   = CW'(1);
                     state_d = (bits_q == 5'd15) ? CHECK : LOW;
                  end
               end else if (cnt_q == BIT_LIM) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            LOW: begin
               if (rise) begin
                  state_d = HIGH;
                  cnt_d   = CW'(1);
               end else if (cnt_q == LOW_LIM) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            CHECK: begin
               state_d = IDLE;
               // an accept in the expiry cycle overrides the failsafe
               if (sh_q[3:0] == crc) begin
                  thr_d = v_thr;
                  tel_d = v[0];
                  spd_d = (v_thr > 11'd47) ? 8'((v_thr - 11'd48) >> 3) : 8'd0;
                  fv_d  = 1'b1;
                  cmd_d = (v_thr != 11'd0) && (v_thr <= 11'd47);
                  to_d  = '0;
                  fs_d  = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            bits_q  <= '0;
            to_q    <= '0;
            thr_q   <= '0;
            tel_q   <= 1'b0;
            spd_q   <= '0;
            fv_q    <= 1'b0;
            cmd_q   <= 1'b0;
            err_q   <= 1'b0;
            fs_q    <= 1'b1;
         end else begin
            s1_q    <= dshot_in[i];
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bits_q  <= bits_d;
            to_q    <= to_d;
            thr_q   <= thr_d;
            tel_q   <= tel_d;
            spd_q   <= spd_d;
            fv_q    <= fv_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            fs_q    <= fs_d;
         end
      end

      assign throttle[11*i +: 11] = thr_q;
      assign speed[8*i +: 8]      = spd_q;
      assign telem[i]             = tel_q;
      assign frame_valid[i]       = fv_q;
      assign cmd_valid[i]         = cmd_q;
      assign frame_err[i]         = err_q;
      assign failsafe[i]          = fs_q;
   end

endmodule

// File: tb/tb_dshot_rx_bank.sv
// tb_dshot_rx_bank: table vectors, directed corner cases and random
// frames checked against a frame-level reference model.
module tb_dshot_rx_bank;
   localparam int NCH = 4;
   localparam int TO  = 5000;
   localparam int BP  = 107;
   localparam int LEN = 16 * BP + 210;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NCH-1:0] dshot_in = '0;
   logic [NCH*11-1:0] throttle;
   logic [NCH-1:0] telem;
   logic [NCH*8-1:0] speed;
   logic [NCH-1:0] frame_valid;
   logic [NCH-1:0] cmd_valid;
   logic [NCH-1:0] frame_err;
   logic [NCH-1:0] failsafe;

   always #5 clk = ~clk;

   dshot_rx_bank #(
      .NUM_CH(NCH),
      .CLK_HZ(16000000),
      .DSHOT_RATE(150000),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dshot_in(dshot_in),
      .throttle(throttle),
      .telem(telem),
      .speed(speed),
      .frame_valid(frame_valid),
      .cmd_valid(cmd_valid),
      .frame_err(frame_err),
      .failsafe(failsafe)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int fv_n[NCH], fe_n[NCH], cm_n[NCH], fv_last[NCH];
   always @(negedge clk) begin
      for (int ch = 0; ch < NCH; ch++) begin
         if (frame_valid[ch]) begin
            fv_n[ch] <= fv_n[ch] + 1;
            fv_last[ch] <= cyc;
         end
         if (frame_err[ch]) fe_n[ch] <= fe_n[ch] + 1;
         if (cmd_valid[ch]) cm_n[ch] <= cm_n[ch] + 1;
      end
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input int ch,
                      input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s ch%0d got=%0d want=%0d", name, ch, got, exp);
      end
   endtask

   // transmit plan per channel
   logic [15:0] tx_fr[NCH];
   int tx_sk[NCH], tx_nb[NCH];
   bit tx_gl[NCH];
   int c0;

   // reference model state
   int m_thr[NCH], m_fv[NCH], m_fe[NCH], m_cm[NCH], m_acc[NCH];
   bit m_tel[NCH], m_seen[NCH];

   function automatic logic [3:0] crc4(input logic [11:0] v);
      logic [11:0] x;
      x = v ^ (v >> 4) ^ (v >> 8);
      return x[3:0];
   endfunction

   task automatic set_idle();
      for (int ch = 0; ch < NCH; ch++) begin
         tx_fr[ch] = '0;
         tx_sk[ch] = 0;
         tx_nb[ch] = 0;
         tx_gl[ch] = 1'b0;
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         m_thr[ch] = 0;
         m_tel[ch] = 1'b0;
         m_seen[ch] = 1'b0;
      end
   endtask

   // 1-bit: 80 high, 0-bit: 40 high, 107-cycle period
   task automatic send(input int stop_at);
      logic [NCH-1:0] lv;
      int tp, bi, off;
      for (int t = 0; t < LEN && t != stop_at; t++) begin
         @(posedge clk);
         #1;
         if (t == 0) c0 = cyc;
         for (int ch = 0; ch < NCH; ch++) begin
            tp = t - tx_sk[ch];
            lv[ch] = 1'b0;
            if (tp >= 0) begin
               bi = tp / BP;
               off = tp % BP;
               if (bi < tx_nb[ch])
                  lv[ch] = off < (tx_fr[ch][15-bi] ? 80 : 40);
               else if (tx_gl[ch] && bi == tx_nb[ch])
                  lv[ch] = off >= 20 && off < 28;
            end
         end
         dshot_in = lv;
      end
   endtask

   task automatic verify();
      logic [11:0] v;
      int hi, spd;
      bit fs;
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
         if (tx_nb[ch] == 16) begin
            v = tx_fr[ch][15:4];
            if (tx_fr[ch][3:0] == crc4(v)) begin
               hi = tx_fr[ch][0] ? 80 : 40;
               m_acc[ch] = c0 + tx_sk[ch] + 15 * BP + hi + 4;
               m_seen[ch] = 1'b1;
               m_thr[ch] = int'(v >> 1);
               m_tel[ch] = v[0];
               m_fv[ch]++;
               if (m_thr[ch] >= 1 && m_thr[ch] <= 47) m_cm[ch]++;
               chk("latency", ch, fv_last[ch], m_acc[ch]);
            end else begin
               m_fe[ch]++;
            end
         end else if (tx_nb[ch] > 0) begin
            m_fe[ch]++;
         end
         fs = !m_seen[ch] || cyc >= m_acc[ch] + TO;
         if (fs) m_thr[ch] = 0;
         spd = m_thr[ch] <= 47 ? 0 : (m_thr[ch] - 48) / 8;
         chk("throttle", ch, throttle[11*ch +: 11], m_thr[ch]);
         chk("telem", ch, telem[ch], m_tel[ch]);
         chk("speed", ch, speed[8*ch +: 8], spd);
         chk("failsafe", ch, failsafe[ch], fs);
         chk("fv_count", ch, fv_n[ch], m_fv[ch]);
         chk("fe_count", ch, fe_n[ch], m_fe[ch]);
         chk("cmd_count", ch, cm_n[ch], m_cm[ch]);
      end
   endtask

   typedef struct {
      logic [15:0] fr;
      int thr;
      bit tel;
      int spd;
      int dfv;
      int dfe;
      int dcm;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int b_fv, b_fe, b_cm, fs_at;
      logic [11:0] rv;

      tbl[0] = '{16'h82C7, 0, 1'b0, 0, 0, 1, 0};
      tbl[1] = '{16'h82C6, 1046, 1'b0, 124, 1, 0, 0};
      tbl[2] = '{16'h0000, 0, 1'b0, 0, 1, 0, 0};
      tbl[3] = '{16'h05FA, 47, 1'b1, 0, 1, 0, 1};
      tbl[4] = '{16'h0606, 48, 1'b0, 0, 1, 0, 0};
      tbl[5] = '{16'h0022, 1, 1'b0, 0, 1, 0, 1};
      tbl[6] = '{16'hFFFF, 2047, 1'b1, 249, 1, 0, 0};

      set_idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_throttle", 0, throttle, 0);
      chk("rst_speed", 0, speed, 0);
      chk("rst_telem", 0, telem, 0);
      chk("rst_failsafe", 0, failsafe, 4'hF);
      chk("rst_pulses", 0, {frame_valid, cmd_valid, frame_err}, 0);
      rst_n = 1'b1;

      for (int r = 0; r < 7; r++) begin
         b_fv = fv_n[0];
         b_fe = fe_n[0];
         b_cm = cm_n[0];
         set_idle();
         tx_fr[0] = tbl[r].fr;
         tx_nb[0] = 16;
         send(LEN);
         verify();
         chk("tbl_thr", r, throttle[10:0], tbl[r].thr);
         chk("tbl_tel", r, telem[0], tbl[r].tel);
         chk("tbl_spd", r, speed[7:0], tbl[r].spd);
         chk("tbl_fv", r, fv_n[0] - b_fv, tbl[r].dfv);
         chk("tbl_fe", r, fe_n[0] - b_fe, tbl[r].dfe);
         chk("tbl_cmd", r, cm_n[0] - b_cm, tbl[r].dcm);
      end

      fs_at = -1;
      for (int k = 0; k < TO + 300 && fs_at < 0; k++) begin
         @(negedge clk);
         if (failsafe[0]) fs_at = cyc;
      end
      chk("fs_rise", 0, fs_at, m_acc[0] + TO);
      chk("fs_thr", 0, throttle[10:0], 0);
      chk("fs_spd", 0, speed[7:0], 0);
      chk("fs_tel", 0, telem[0], 1);

      set_idle();
      tx_fr[0] = 16'h82C6;
      tx_nb[0] = 16;
      tx_fr[1] = 16'h82C6;
      tx_nb[1] = 6;
      tx_gl[1] = 1'b1;
      send(LEN);
      verify();
      set_idle();
      tx_fr[1] = 16'h82C6;
      tx_nb[1] = 16;
      send(LEN);
      verify();

      set_idle();
      tx_fr[0] = 16'h82C6;
      tx_fr[1] = 16'h05FA;
      tx_fr[2] = 16'h0606;
      tx_fr[3] = 16'hFFFF;
      for (int ch = 0; ch < NCH; ch++) begin
         tx_nb[ch] = 16;
         tx_sk[ch] = ch;
      end
      send(LEN);
      verify();

      tx_fr[0] = 16'h0022;
      send(900);
      rst_n = 1'b0;
      dshot_in = '0;
      #1;
      chk("mid_rst_thr", 0, throttle, 0);
      chk("mid_rst_spd", 0, speed, 0);
      chk("mid_rst_tel", 0, telem, 0);
      chk("mid_rst_fs", 0, failsafe, 4'hF);
      chk("mid_rst_pulses", 0, {frame_valid, cmd_valid, frame_err}, 0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (300) @(posedge clk);
      model_reset();
      set_idle();
      verify();

      for (int r = 0; r < 8; r++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            tx_fr[ch] = 16'($urandom);
            rv = tx_fr[ch][15:4];
            if ($urandom_range(3) != 0) tx_fr[ch][3:0] = crc4(rv);
            tx_nb[ch] = ($urandom_range(5) == 0) ? $urandom_range(15, 1) : 16;
            tx_gl[ch] = (tx_nb[ch] < 16) && ($urandom_range(1) == 1);
            tx_sk[ch] = $urandom_range(5);
         end
         send(LEN);
         verify();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
